// File: rtl/wb_port_arbiter_if.sv
// Purpose: bundles the S3 writeback, long-latency result and regfile write port
//          signals shared by the writeback-port arbiter and its environment.
// Backpressure: ll_valid is held with ll_ws/ll_data until ll_ready; pipe_stall
//               makes the pipeline hold its S3 signals for one more cycle.
// Modports: master drives the requests and observes the outputs; slave is the arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PERF_W = 16
);
  logic              s3_we;
  logic [ADDR_W-1:0] s3_ws;
  logic [DATA_W-1:0] s3_data;
  logic              ll_valid;
  logic [ADDR_W-1:0] ll_ws;
  logic [DATA_W-1:0] ll_data;
  logic              ll_ready;
  logic              pipe_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output s3_we, s3_ws, s3_data, ll_valid, ll_ws, ll_data,
    input  ll_ready, pipe_stall, rf_we, rf_wa, rf_wd, stall_cnt
  );

  modport slave (
    input  s3_we, s3_ws, s3_data, ll_valid, ll_ws, ll_data,
    output ll_ready, pipe_stall, rf_we, rf_wa, rf_wd, stall_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Purpose: shares the single regfile write port between S3 writeback (fixed priority)
//          and a long-latency unit, with an aging counter bounding LL starvation.
// Latency: granted write appears on rf_we/rf_wa/rf_wd one cycle after grant.
// Backpressure: ll_ready accepts an LL result; pipe_stall holds S3 when LL wins over it.
// Ports: clk, rst (async active-low), bus (slave side of wb_port_arbiter_if).
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4,
  parameter int STARVE_W   = 3,
  parameter int PERF_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, CONTEND, FORCE} state_t;

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state;
  logic [STARVE_W-1:0] starve;
  logic [STARVE_W-1:0] starve_inc;

  logic p_req;
  logic l_req;
  logic force_ll;
  logic ll_win;
  logic p_win;
  logic stall;

  // Writes to r0 are not requests; an LL result aimed at r0 is simply dropped.
  assign p_req = bus.s3_we & (bus.s3_ws != '0);
  assign l_req = bus.ll_valid & (bus.ll_ws != '0);

  // Same-address contention goes to LL: its result is older than the S3 write,
  // so writing it first leaves the younger pipeline value in the register.
  assign force_ll = (state == FORCE) | (starve >= STARVE_LIM) | (bus.s3_ws == bus.ll_ws);

  assign ll_win = l_req & (~p_req | force_ll);
  assign p_win  = p_req & ~ll_win;
  assign stall  = ll_win & p_req;

  // Combinational handshakes are gated by reset so a pending LL result is not
  // consumed while the block is held in reset.
  assign bus.ll_ready   = rst & bus.ll_valid & (ll_win | (bus.ll_ws == '0));
  assign bus.pipe_stall = rst & stall;

  // starve is always below STARVE_LIM when LL loses, so the increment cannot wrap.
  assign starve_inc = starve + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve        <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_wa     <= '0;
      bus.rf_wd     <= '0;
      bus.stall_cnt <= '0;
    end else begin
      bus.rf_we <= ll_win | p_win;
      if (ll_win) begin
        bus.rf_wa <= bus.ll_ws;
        bus.rf_wd <= bus.ll_data;
      end else if (p_win) begin
        bus.rf_wa <= bus.s3_ws;
        bus.rf_wd <= bus.s3_data;
      end

      if (stall && (bus.stall_cnt != '1)) begin
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
      end

      if (ll_win) begin
        state  <= IDLE;
        starve <= '0;
      end else if (!l_req) begin
        // A pending force survives a gap in LL requests; contention does not.
        starve <= '0;
        if (state != FORCE) begin
          state <= IDLE;
        end
      end else if (p_win) begin
        // LL requested and lost: age it, forcing it once the limit is reached.
        starve <= starve_inc;
        state  <= (starve_inc >= STARVE_LIM) ? FORCE : CONTEND;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5), .PERF_W(4)) bus ();

  wb_port_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_MAX(4), .STARVE_W(3), .PERF_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mirror [32];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the registered write produced by the previous step's grant.
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, ".rf_we"}, {31'd0, bus.rf_we}, {31'd0, e.we});
    if (e.we) begin
      chk({e.tag, ".rf_wa"}, {27'd0, bus.rf_wa}, {27'd0, e.wa});
      chk({e.tag, ".rf_wd"}, bus.rf_wd, e.wd);
    end
    if (bus.rf_we === 1'b1) mirror[bus.rf_wa] = bus.rf_wd;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pws, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lws, input logic [31:0] ld);
    bus.s3_we    = pwe;
    bus.s3_ws    = pws;
    bus.s3_data  = pd;
    bus.ll_valid = lv;
    bus.ll_ws    = lws;
    bus.ll_data  = ld;
  endtask

  task automatic step(input string tag,
                      input logic pwe, input logic [4:0] pws, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lws, input logic [31:0] ld,
                      input logic erdy, input logic estall,
                      input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
    @(negedge clk);
    pop_check();
    drive(pwe, pws, pd, lv, lws, ld);
    #2;
    chk({tag, ".ll_ready"}, {31'd0, bus.ll_ready}, {31'd0, erdy});
    chk({tag, ".pipe_stall"}, {31'd0, bus.pipe_stall}, {31'd0, estall});
    sb.push_back('{ewe, ewa, ewd, tag});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mirror[i] = 32'd0;

    // Reset held with both requesters active.
    drive(1'b1, 5'd5, 32'h1234, 1'b1, 5'd7, 32'h5678);
    repeat (2) @(negedge clk);
    #2;
    chk("rst.rf_we",      {31'd0, bus.rf_we},      32'd0);
    chk("rst.rf_wa",      {27'd0, bus.rf_wa},      32'd0);
    chk("rst.rf_wd",      bus.rf_wd,               32'd0);
    chk("rst.stall_cnt",  {28'd0, bus.stall_cnt},  32'd0);
    chk("rst.ll_ready",   {31'd0, bus.ll_ready},   32'd0);
    chk("rst.pipe_stall", {31'd0, bus.pipe_stall}, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;

    // Plain pipeline write.
    step("pipe5", 1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 32'd0, 0, 0, 1, 5'd5, 32'hA5A5A5A5);
    step("idle0", 0, 5'd0, 32'd0,        0, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);

    // Starvation: LL loses four cycles, then is forced and stalls the pipeline.
    for (int i = 0; i < 4; i++)
      step($sformatf("starve%0d", i), 1, 5'd3, 32'h300 + i, 1, 5'd7, 32'h77, 0, 0, 1, 5'd3, 32'h300 + i);
    step("force", 1, 5'd3, 32'h304, 1, 5'd7, 32'h77, 1, 1, 1, 5'd7, 32'h77);
    step("repres", 1, 5'd3, 32'h304, 0, 5'd0, 32'd0, 0, 0, 1, 5'd3, 32'h304);
    chk("starve.stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);

    // Same destination: older LL result is written first.
    step("same9",  1, 5'd9, 32'h9999, 1, 5'd9, 32'h1111, 1, 1, 1, 5'd9, 32'h1111);
    step("same9b", 1, 5'd9, 32'h9999, 0, 5'd0, 32'd0,    0, 0, 1, 5'd9, 32'h9999);
    chk("same.stall_cnt", {28'd0, bus.stall_cnt}, 32'd2);

    // r0 requests are not requests.
    step("p_ws0",  1, 5'd0, 32'hDEAD, 1, 5'd2, 32'h2222, 1, 0, 1, 5'd2, 32'h2222);
    step("l_ws0",  0, 5'd0, 32'd0,    1, 5'd0, 32'h3333, 1, 0, 0, 5'd0, 32'd0);
    step("l_ws0p", 1, 5'd4, 32'h4444, 1, 5'd0, 32'h3333, 1, 0, 1, 5'd4, 32'h4444);

    // Drive the stall counter to saturation and past it.
    for (int i = 0; i < 13; i++) begin
      step("sat_s", 1, 5'd10, 32'hA0 + i, 1, 5'd10, 32'hB0 + i, 1, 1, 1, 5'd10, 32'hB0 + i);
      step("sat_p", 1, 5'd10, 32'hA0 + i, 0, 5'd0,  32'd0,      0, 0, 1, 5'd10, 32'hA0 + i);
    end
    chk("sat.stall_cnt", {28'd0, bus.stall_cnt}, 32'hF);
    step("sat_s2", 1, 5'd10, 32'hC0, 1, 5'd10, 32'hD0, 1, 1, 1, 5'd10, 32'hD0);
    step("sat_p2", 1, 5'd10, 32'hC0, 0, 5'd0,  32'd0,  0, 0, 1, 5'd10, 32'hC0);
    chk("sat_hold.stall_cnt", {28'd0, bus.stall_cnt}, 32'hF);

    // Reset asserted mid-contention (starve=2), between clock edges.
    step("pre0", 1, 5'd3, 32'h500, 1, 5'd7, 32'h88, 0, 0, 1, 5'd3, 32'h500);
    step("pre1", 1, 5'd3, 32'h501, 1, 5'd7, 32'h88, 0, 0, 1, 5'd3, 32'h501);
    @(negedge clk);
    pop_check();
    rst = 1'b0;
    #2;
    chk("mid_rst.rf_we",      {31'd0, bus.rf_we},      32'd0);
    chk("mid_rst.rf_wa",      {27'd0, bus.rf_wa},      32'd0);
    chk("mid_rst.rf_wd",      bus.rf_wd,               32'd0);
    chk("mid_rst.stall_cnt",  {28'd0, bus.stall_cnt},  32'd0);
    chk("mid_rst.ll_ready",   {31'd0, bus.ll_ready},   32'd0);
    chk("mid_rst.pipe_stall", {31'd0, bus.pipe_stall}, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    sb.push_back('{1'b0, 5'd0, 32'd0, "post_rst"});

    // Aging restarts from zero: four full losses again before the force.
    for (int i = 0; i < 4; i++)
      step($sformatf("re_starve%0d", i), 1, 5'd3, 32'h600 + i, 1, 5'd7, 32'h99, 0, 0, 1, 5'd3, 32'h600 + i);
    step("re_force",  1, 5'd3, 32'h604, 1, 5'd7, 32'h99, 1, 1, 1, 5'd7, 32'h99);
    step("re_repres", 1, 5'd3, 32'h604, 0, 5'd0, 32'd0,  0, 0, 1, 5'd3, 32'h604);
    chk("re.stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);

    step("final", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
    @(negedge clk);
    pop_check();
    chk("sb_empty", sb.size(), 32'd0);
    chk("reg9", mirror[9], 32'h9999);
    chk("reg7", mirror[7], 32'h99);
    chk("reg3", mirror[3], 32'h604);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
